// File: rtl/input_ram_arbiter.sv
// Shares one single-port input-matrix RAM between the host loader and the accelerator.
// Round-robin ownership with burst-limited tenures; read data returns one cycle after each read access.
module input_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  input  logic              acc_req,
  input  logic [ADDR_W-1:0] acc_addr,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, HOST, ACC} state_t;

  // last_owner: 0 = host served last, 1 = accelerator served last
  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_ACC  = 1'b1;

  state_t           state, state_nxt;
  logic             last_owner, last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic [CNT_W-1:0] burst_inc;
  logic             host_access, acc_access;

  assign host_gnt = (state == HOST);
  assign acc_gnt  = (state == ACC);

  // Accesses are blocked while reset is asserted so the RAM never sees a stray cycle.
  assign host_access = reset && host_gnt && host_req;
  assign acc_access  = reset && acc_gnt && acc_req;

  assign ram_en    = host_access | acc_access;
  assign ram_we    = host_access & host_we;
  assign ram_addr  = host_access ? host_addr : (acc_access ? acc_addr : '0);
  assign ram_wdata = host_access ? host_wdata : '0;
  assign rdata     = ram_rdata;

  assign burst_inc = burst_cnt + CNT_W'(1);

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (acc_req && (!host_req || last_owner == OWN_HOST)) begin
          state_nxt      = ACC;
          last_owner_nxt = OWN_ACC;
        end else if (host_req) begin
          state_nxt      = HOST;
          last_owner_nxt = OWN_HOST;
        end
      end
      HOST: begin
        if (!host_req || burst_inc == BURST_MAX) begin
          burst_cnt_nxt = '0;
          if (acc_req) begin
            state_nxt      = ACC;
            last_owner_nxt = OWN_ACC;
          end else if (!host_req) begin
            state_nxt = IDLE;
          end
        end else begin
          burst_cnt_nxt = burst_inc;
        end
      end
      ACC: begin
        if (!acc_req || burst_inc == BURST_MAX) begin
          burst_cnt_nxt = '0;
          if (host_req) begin
            state_nxt      = HOST;
            last_owner_nxt = OWN_HOST;
          end else if (!acc_req) begin
            state_nxt = IDLE;
          end
        end else begin
          burst_cnt_nxt = burst_inc;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_owner  <= OWN_HOST;
      burst_cnt   <= '0;
      host_rvalid <= 1'b0;
      acc_rvalid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_owner  <= last_owner_nxt;
      burst_cnt   <= burst_cnt_nxt;
      host_rvalid <= host_access & ~host_we;
      acc_rvalid  <= acc_access;
    end
  end

endmodule

// File: tb/tb_input_ram_arbiter.sv
// Directed bench for input_ram_arbiter: vector table plus burst, round-robin and reset sequences.
module tb_input_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        host_req, host_we, acc_req;
  logic [9:0]  host_addr, acc_addr, ram_addr;
  logic [15:0] host_wdata, ram_wdata, ram_rdata, rdata;
  logic        host_gnt, host_rvalid, acc_gnt, acc_rvalid, ram_en, ram_we;

  int pass_cnt = 0;
  int total_cnt = 0;

  input_ram_arbiter #(.ADDR_W(10), .DATA_W(16), .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .acc_req(acc_req), .acc_addr(acc_addr), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small RAM model; unwritten locations read back as 0xC000 | addr.
  logic [15:0] mem [16];
  logic        wr  [16] = '{default: 1'b0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr[3:0]] <= ram_wdata;
        wr[ram_addr[3:0]]  <= 1'b1;
      end else begin
        ram_rdata <= wr[ram_addr[3:0]] ? mem[ram_addr[3:0]] : (16'hC000 | {12'h0, ram_addr[3:0]});
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        hreq;
    logic        hwe;
    logic [9:0]  haddr;
    logic [15:0] hwd;
    logic        areq;
    logic [9:0]  aaddr;
    logic [5:0]  ctl;    // {host_gnt, acc_gnt, host_rvalid, acc_rvalid, ram_en, ram_we}
    logic [9:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic clear_inputs();
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    acc_req = 0; acc_addr = '0;
  endtask

  // Leaves the bench at a falling edge with reset just released (first cycle after release).
  task automatic apply_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [2:0] exp_own;
  int         acc_count;

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 10'd3, 16'h0000, 1'b0, 10'd0, 6'b000000, 10'd0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd5, 6'b000000, 10'd0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd5, 6'b010010, 10'd5, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 10'd5, 6'b010100, 10'd0, 16'h0000, 16'hC005};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 10'd0, 16'h00A0, 1'b1, 10'd0, 6'b000000, 10'd0, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 10'd0, 16'h00A0, 1'b1, 10'd0, 6'b100011, 10'd0, 16'h00A0, 16'h0000};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 10'd1, 16'h00A1, 1'b1, 10'd0, 6'b100011, 10'd1, 16'h00A1, 16'h0000};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 10'd2, 16'h00A2, 1'b1, 10'd0, 6'b100011, 10'd2, 16'h00A2, 16'h0000};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 10'd3, 16'h00A3, 1'b1, 10'd0, 6'b100011, 10'd3, 16'h00A3, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd0, 6'b100000, 10'd0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd0, 6'b010010, 10'd0, 16'h0000, 16'h0000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd1, 6'b010110, 10'd1, 16'h0000, 16'h00A0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd2, 6'b010110, 10'd2, 16'h0000, 16'h00A1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd3, 6'b010110, 10'd3, 16'h0000, 16'h00A2};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 10'd3, 6'b010100, 10'd0, 16'h0000, 16'h00A3};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 10'd2, 16'h0000, 1'b0, 10'd0, 6'b000000, 10'd0, 16'h0000, 16'h0000};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 10'd2, 16'h0000, 1'b1, 10'd7, 6'b100010, 10'd2, 16'h0000, 16'h0000};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd7, 6'b101000, 10'd0, 16'h0000, 16'h00A2};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b1, 10'd7, 6'b010010, 10'd7, 16'h0000, 16'h0000};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 10'd0, 6'b010100, 10'd0, 16'h0000, 16'hC007};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 10'd0, 6'b000000, 10'd0, 16'h0000, 16'h0000};

    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      host_req = tbl[i].hreq; host_we = tbl[i].hwe;
      host_addr = tbl[i].haddr; host_wdata = tbl[i].hwd;
      acc_req = tbl[i].areq; acc_addr = tbl[i].aaddr;
      #1;
      chk($sformatf("vec%0d", i),
          {32'h0, host_gnt, acc_gnt, host_rvalid, acc_rvalid, ram_en, ram_we, ram_addr, ram_wdata},
          {32'h0, tbl[i].ctl, tbl[i].addr, tbl[i].wd});
      if (tbl[i].ctl[3] || tbl[i].ctl[2])
        chk($sformatf("vec%0d_rdata", i), {48'h0, rdata}, {48'h0, tbl[i].rd});
    end

    // Simultaneous requests after reset: accelerator first, then host with no idle cycle.
    apply_reset();
    host_req = 1; host_addr = 10'd9; acc_req = 1; acc_addr = 10'd4;
    #1 chk("rr_idle", {61'h0, host_gnt, acc_gnt, ram_en}, 64'b000);
    @(negedge clk); #1 chk("rr_acc_first", {61'h0, host_gnt, acc_gnt, ram_en}, 64'b011);
    @(negedge clk); #1 chk("rr_acc_hold", {61'h0, host_gnt, acc_gnt, ram_en}, 64'b011);
    @(negedge clk); acc_req = 0;
    #1 chk("rr_acc_drop", {61'h0, host_gnt, acc_gnt, ram_en}, 64'b010);
    @(negedge clk); #1 chk("rr_host_next", {51'h0, host_gnt, acc_gnt, ram_en, ram_addr}, {51'h0, 3'b101, 10'd9});

    // Both requesting for 40 cycles: 16-access tenures alternate without bubbles.
    apply_reset();
    host_req = 1; acc_req = 1; acc_addr = 10'd1; host_addr = 10'd2;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c == 0)       exp_own = 3'b000;
      else if (c <= 16) exp_own = 3'b011;
      else if (c <= 32) exp_own = 3'b101;
      else              exp_own = 3'b011;
      chk($sformatf("burst_c%0d", c), {61'h0, host_gnt, acc_gnt, ram_en}, {61'h0, exp_own});
    end

    // Accelerator alone: ownership continues across the burst limit.
    apply_reset();
    acc_req = 1; acc_addr = 10'd3;
    acc_count = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (acc_gnt && ram_en) acc_count++;
      if (c > 0) chk($sformatf("acc_cont_c%0d", c), {62'h0, acc_gnt, ram_en}, 64'b11);
    end
    @(negedge clk); acc_req = 0;
    chk("acc_count", 64'(acc_count), 64'd20);

    // Reset mid host read burst.
    apply_reset();
    host_req = 1; host_addr = 10'd1;
    @(negedge clk); #1 chk("rst_host_rd", {62'h0, host_gnt, ram_en}, 64'b11);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    #1 chk("rst_mid", {59'h0, host_gnt, acc_gnt, host_rvalid, acc_rvalid, ram_en}, 64'h0);
    reset = 1'b1;
    #1 chk("rst_release", {62'h0, host_gnt, ram_en}, 64'b00);
    @(negedge clk); #1 chk("rst_regrant", {62'h0, host_gnt, ram_en}, 64'b11);

    clear_inputs();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
